ioctl_ram_loader: RTL and testbench

Downstream consumer of the MiST SPI I/O block's ioctl download port. It packs the byte stream (ROM, tape or snapshot image) into 16-bit little-endian RAM writes with byte enables, and buffers them in a small FIFO. It issues writes to the SDRAM controller over a req/ack handshake and throttles the source via `ioctl_ce`. It also reports size and completion to the core.

---
 rtl/ioctl_ram_loader_if.sv | 49 ++++
 rtl/ioctl_ram_loader.sv | 251 +++++++++++++++++++++++++
 tb/tb_ioctl_ram_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_ram_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_ram_loader_if
// Description : Bundles the ioctl download port and the SDRAM write port
//               used by ioctl_ram_loader.
//   ioctl_download  download active (level)
//   ioctl_index     image type
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte offset within the image
//   ioctl_dout      byte data
//   ioctl_ce        source clock enable (low = backpressure)
//   ram_req         write request (level)
//   ram_addr        word address
//   ram_din         write data, even byte in [7:0]
//   ram_be          byte enables
//   ram_ack         one-cycle completion pulse
//   master : the loader side      slave : source + SDRAM controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface ioctl_ram_loader_if #(
  parameter int ADDR_W = 25
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_ce;
  logic              ram_req;
  logic [ADDR_W-2:0] ram_addr;
  logic [15:0]       ram_din;
  logic [1:0]        ram_be;
  logic              ram_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_ce,
    output ram_req, ram_addr, ram_din, ram_be,
    input  ram_ack
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_ce,
    input  ram_req, ram_addr, ram_din, ram_be,
    output ram_ack
  );
endinterface
`default_nettype wire

// File: rtl/ioctl_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_ram_loader
// Description : Packs the ioctl download byte stream into 16-bit
//               little-endian RAM writes with byte enables, buffers them in
//               a small FIFO and issues them over a req/ack handshake.
// Ports       :
//   clk_sys     system clock
//   reset_n     asynchronous active-low reset
//   bus         ioctl_ram_loader_if.master (ioctl source + RAM write port)
//   load_busy   high while loading or flushing
//   load_done   one-cycle pulse at end of load
//   load_size   bytes in the last image (last addr + 1)
//   rom_loaded  sticky, a ROM (index 0) load has completed
//   load_err    sticky, a byte was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_ram_loader #(
  parameter int                ADDR_W    = 25,
  parameter logic [ADDR_W-1:0] ROM_BASE  = '0,
  parameter logic [ADDR_W-1:0] FILE_BASE = ADDR_W'(25'h0100000),
  parameter int                FIFO_LOG2 = 2
) (
  input  wire logic          clk_sys,
  input  wire logic          reset_n,
  ioctl_ram_loader_if.master bus,
  output logic               load_busy,
  output logic               load_done,
  output logic [24:0]        load_size,
  output logic               rom_loaded,
  output logic               load_err
);

  localparam int                 C_DEPTH    = 1 << FIFO_LOG2;
  localparam int                 C_WA_W     = ADDR_W - 1;
  localparam int                 C_ENTRY_W  = C_WA_W + 16 + 2;
  localparam logic [FIFO_LOG2:0] C_FULL     = (FIFO_LOG2+1)'(C_DEPTH);
  localparam logic [FIFO_LOG2:0] C_CE_LIMIT = (FIFO_LOG2+1)'(C_DEPTH - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } load_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_REQ  = 1'b1
  } ram_state_t;

  load_state_t r_state, w_state_nxt;
  ram_state_t  r_rstate, w_rstate_nxt;

  // FIFO storage and bookkeeping
  logic [C_ENTRY_W-1:0] r_mem [C_DEPTH];
  logic [FIFO_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_LOG2:0]   r_count;

  // Packer: at most one byte waiting for its partner lane
  logic              r_pend_valid;
  logic [C_WA_W-1:0] r_pend_wa;
  logic              r_pend_lane;
  logic [7:0]        r_pend_data;

  logic [7:0]        r_index;
  logic [24:0]       r_load_size;
  logic              r_rom_loaded;
  logic              r_load_err;
  logic              r_ce;
  logic [C_WA_W-1:0] r_ram_addr;
  logic [15:0]       r_ram_din;
  logic [1:0]        r_ram_be;

  logic [ADDR_W-1:0]    w_base, w_ba;
  logic [C_WA_W-1:0]    w_wa;
  logic                 w_lane;
  logic                 w_accept, w_start;
  logic                 w_push, w_push_ok, w_drop, w_pop, w_issue;
  logic                 w_pend_take, w_pend_clear;
  logic [C_ENTRY_W-1:0] w_push_entry, w_pend_entry, w_head;

  assign w_base   = (r_index == 8'd0) ? ROM_BASE : FILE_BASE;
  assign w_ba     = w_base + ADDR_W'(bus.ioctl_addr);
  assign w_wa     = w_ba[ADDR_W-1:1];
  assign w_lane   = w_ba[0];
  assign w_accept = (r_state == S_LOAD) && bus.ioctl_wr;
  assign w_start  = (r_state == S_IDLE) && bus.ioctl_download;

  // The pending byte on its own, the other lane zero
  assign w_pend_entry = r_pend_lane ? {r_pend_wa, r_pend_data, 8'h00, 2'b10}
                                    : {r_pend_wa, 8'h00, r_pend_data, 2'b01};

  always_comb begin
    w_push       = 1'b0;
    w_push_entry = '0;
    w_pend_take  = 1'b0;
    w_pend_clear = 1'b0;
    if (w_accept) begin
      if (r_pend_valid && (r_pend_wa == w_wa) && (r_pend_lane != w_lane)) begin
        w_push       = 1'b1;
        w_push_entry = w_lane ? {w_wa, bus.ioctl_dout, r_pend_data, 2'b11}
                              : {w_wa, r_pend_data, bus.ioctl_dout, 2'b11};
        w_pend_clear = 1'b1;
      end else begin
        w_push       = r_pend_valid;
        w_push_entry = w_pend_entry;
        w_pend_take  = 1'b1;
      end
    end else if ((r_state == S_FLUSH) && r_pend_valid) begin
      // A trailing odd byte leaves as a single-lane write
      w_push       = 1'b1;
      w_push_entry = w_pend_entry;
      w_pend_clear = 1'b1;
    end
  end

  assign w_push_ok = w_push && (r_count != C_FULL);
  assign w_drop    = w_push && (r_count == C_FULL);
  assign w_pop     = (r_rstate == R_REQ) && bus.ram_ack;
  assign w_issue   = (r_rstate == R_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];

  // Loader FSM
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.ioctl_download) w_state_nxt = S_LOAD;
      S_LOAD: begin
        load_busy = 1'b1;
        if (!bus.ioctl_download) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        load_busy = 1'b1;
        if (!r_pend_valid && (r_count == '0) && (r_rstate == R_IDLE))
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        load_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // RAM request FSM
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (r_count != '0) w_rstate_nxt = R_REQ;
      R_REQ:   if (bus.ram_ack)   w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // The RAM port is captured once per request and stays frozen until ack
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_be   <= '0;
    end else if (w_issue) begin
      r_ram_addr <= w_head[C_ENTRY_W-1 -: C_WA_W];
      r_ram_din  <= w_head[17:2];
      r_ram_be   <= w_head[1:0];
    end
  end

  // FIFO storage carries no reset; only the pointers and count matter
  always_ff @(posedge clk_sys) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Packer pending byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_valid <= 1'b0;
      r_pend_wa    <= '0;
      r_pend_lane  <= 1'b0;
      r_pend_data  <= '0;
    end else if (w_start || w_pend_clear) begin
      r_pend_valid <= 1'b0;
    end else if (w_pend_take) begin
      r_pend_valid <= 1'b1;
      r_pend_wa    <= w_wa;
      r_pend_lane  <= w_lane;
      r_pend_data  <= bus.ioctl_dout;
    end
  end

  // Status, index latch and source throttle
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_index      <= '0;
      r_load_size  <= '0;
      r_rom_loaded <= 1'b0;
      r_load_err   <= 1'b0;
      r_ce         <= 1'b1;
    end else begin
      if (w_start) begin
        r_index     <= bus.ioctl_index;
        r_load_size <= '0;
      end else if (w_accept) begin
        r_load_size <= bus.ioctl_addr + 25'd1;
      end
      if ((r_state == S_DONE) && (r_index == 8'd0)) r_rom_loaded <= 1'b1;
      if (w_drop) r_load_err <= 1'b1;
      // Leaves room for the pending byte plus one in-flight pair
      r_ce <= (r_count <= C_CE_LIMIT) && ((r_state == S_IDLE) || (r_state == S_LOAD));
    end
  end

  assign bus.ioctl_ce = r_ce;
  assign bus.ram_req  = (r_rstate == R_REQ);
  assign bus.ram_addr = r_ram_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.ram_be   = r_ram_be;
  assign load_size    = r_load_size;
  assign rom_loaded   = r_rom_loaded;
  assign load_err     = r_load_err;

endmodule
`default_nettype wire

// File: tb/tb_ioctl_ram_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ioctl_ram_loader
// Description : Self-checking bench for ioctl_ram_loader. A byte-list
//               reference model predicts the RAM write sequence; a responder
//               acks requests and records what the DUT wrote.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ioctl_ram_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        load_busy, load_done, rom_loaded, load_err;
  logic [24:0] load_size;

  always #5 clk_sys = ~clk_sys;

  ioctl_ram_loader_if #(.ADDR_W(25)) bus();

  ioctl_ram_loader #(
    .ADDR_W   (25),
    .ROM_BASE (25'h0000000),
    .FILE_BASE(25'h0100000),
    .FIFO_LOG2(2)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_size (load_size),
    .rom_loaded(rom_loaded),
    .load_err  (load_err)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } wr_t;

  wr_t        obs_q[$];
  wr_t        exp_q[$];
  int         src_addr[$];
  logic [7:0] src_data[$];

  int errors = 0;
  int checks = 0;
  int ack_delay = 1;
  bit ack_enable = 1'b1;
  int stab_err = 0;
  int done_cnt = 0;
  bit ce_low_seen = 1'b0;
  bit rom_exp = 1'b0;
  bit err_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: records each request, checks it is held, then acks
  initial begin
    wr_t cur;
    bus.ram_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      bus.ram_ack = 1'b0;
      if (reset_n && ack_enable && bus.ram_req) begin
        cur = '{a: bus.ram_addr, d: bus.ram_din, be: bus.ram_be};
        obs_q.push_back(cur);
        for (int k = 0; k < ack_delay; k++) begin
          @(negedge clk_sys);
          if (reset_n && (!bus.ram_req || bus.ram_addr != cur.a ||
                          bus.ram_din != cur.d || bus.ram_be != cur.be))
            stab_err++;
        end
        bus.ram_ack = 1'b1;
      end
    end
  end

  // Passive monitor
  initial begin
    forever begin
      @(negedge clk_sys);
      if (reset_n && load_done) done_cnt++;
      if (load_busy && !bus.ioctl_ce) ce_low_seen = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: byte image -> 16-bit little-endian writes, pairing only
  // consecutive bytes that share a word in opposite lanes
  task automatic build_expected(input logic [7:0] idx);
    int  base, ba;
    bit  pv;
    int  pw, pl;
    logic [7:0] pd;
    wr_t e;
    base = (idx == 8'd0) ? 32'h0 : 32'h0100000;
    pv = 1'b0; pw = 0; pl = 0; pd = 8'h00;
    exp_q.delete();
    foreach (src_addr[i]) begin
      ba = base + src_addr[i];
      if (pv && pw == ba / 2 && pl != ba % 2) begin
        e.a  = 24'(pw);
        e.d  = (pl == 0) ? {src_data[i], pd} : {pd, src_data[i]};
        e.be = 2'b11;
        exp_q.push_back(e);
        pv = 1'b0;
      end else begin
        if (pv) begin
          e.a  = 24'(pw);
          e.d  = (pl == 0) ? {8'h00, pd} : {pd, 8'h00};
          e.be = (pl == 0) ? 2'b01 : 2'b10;
          exp_q.push_back(e);
        end
        pv = 1'b1; pw = ba / 2; pl = ba % 2; pd = src_data[i];
      end
    end
    if (pv) begin
      e.a  = 24'(pw);
      e.d  = (pl == 0) ? {8'h00, pd} : {pd, 8'h00};
      e.be = (pl == 0) ? 2'b01 : 2'b10;
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_src();
    src_addr.delete();
    src_data.delete();
  endtask

  task automatic add_byte(input int a, input logic [7:0] d);
    src_addr.push_back(a);
    src_data.push_back(d);
  endtask

  task automatic start_load(input logic [7:0] idx);
    int n;
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    done_cnt = 0;
    stab_err = 0;
    obs_q.delete();
    n = 0;
    while (!load_busy && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("enter_load", {63'd0, load_busy}, 64'd1);
  endtask

  task automatic send_bytes(input bit honour, input bit gaps);
    int w;
    foreach (src_addr[i]) begin
      w = 0;
      while (honour && !bus.ioctl_ce && w < 500) begin
        @(negedge clk_sys);
        w++;
      end
      if (w >= 500) check("ce_wait", {63'd0, bus.ioctl_ce}, 64'd1);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = 25'(src_addr[i]);
      bus.ioctl_dout = src_data[i];
      @(negedge clk_sys);
      bus.ioctl_wr = 1'b0;
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk_sys);
    end
  endtask

  task automatic finish_load(input logic [7:0] idx, input int trunc);
    int n, m;
    build_expected(idx);
    if (trunc > 0) while (exp_q.size() > trunc) void'(exp_q.pop_back());
    bus.ioctl_download = 1'b0;
    n = 0;
    while (!load_done && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check("done_seen", {63'd0, load_done}, 64'd1);
    check("done_latency", {63'd0, (n >= 2)}, 64'd1);
    repeat (3) @(negedge clk_sys);
    if (idx == 8'd0) rom_exp = 1'b1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("load_size", 64'(load_size), 64'(src_addr[src_addr.size()-1] + 1));
    check("rom_loaded", {63'd0, rom_loaded}, {63'd0, rom_exp});
    check("load_err", {63'd0, load_err}, {63'd0, err_exp});
    check("busy_cleared", {63'd0, load_busy}, 64'd0);
    check("req_held", 64'(stab_err), 64'd0);
    check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("write%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  initial begin
    int n;
    int a;
    logic [7:0] idx;
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(negedge clk_sys);

    check("rst_ce", {63'd0, bus.ioctl_ce}, 64'd1);
    check("rst_req", {63'd0, bus.ram_req}, 64'd0);
    check("rst_busy", {63'd0, load_busy}, 64'd0);
    check("rst_done", {63'd0, load_done}, 64'd0);
    check("rst_size", 64'(load_size), 64'd0);
    check("rst_rom", {63'd0, rom_loaded}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // A strobe outside a download must not reach RAM
    bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd0; bus.ioctl_dout = 8'hEE;
    @(negedge clk_sys);
    bus.ioctl_wr = 1'b0;

    // ROM load, four bytes
    ack_delay = 1;
    clear_src();
    add_byte(0, 8'h11); add_byte(1, 8'h22); add_byte(2, 8'h33); add_byte(3, 8'h44);
    start_load(8'd0);
    send_bytes(1'b1, 1'b0);
    finish_load(8'd0, 0);

    // Odd length, file base
    clear_src();
    add_byte(0, 8'hAA); add_byte(1, 8'hBB); add_byte(2, 8'hCC);
    start_load(8'd1);
    send_bytes(1'b1, 1'b0);
    finish_load(8'd1, 0);

    // Non-contiguous addresses
    clear_src();
    add_byte(1, 8'h5A); add_byte(4, 8'hC3);
    start_load(8'd0);
    send_bytes(1'b1, 1'b0);
    finish_load(8'd0, 0);

    // Backpressure with slow acks
    ack_delay = 20;
    ce_low_seen = 1'b0;
    clear_src();
    for (int i = 0; i < 8; i++) add_byte(i, 8'($urandom_range(0, 255)));
    start_load(8'd2);
    send_bytes(1'b1, 1'b0);
    finish_load(8'd2, 0);
    check("ce_backpressure", {63'd0, ce_low_seen}, 64'd1);

    // Overflow: acks held off, source ignores ioctl_ce
    ack_delay = 1;
    ack_enable = 1'b0;
    clear_src();
    for (int i = 0; i < 16; i++) add_byte(i, 8'($urandom_range(0, 255)));
    start_load(8'd0);
    send_bytes(1'b0, 1'b0);
    bus.ioctl_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    err_exp = 1'b1;
    check("ovf_err", {63'd0, load_err}, 64'd1);
    check("ovf_no_write_yet", 64'(obs_q.size()), 64'd0);
    ack_enable = 1'b1;
    finish_load(8'd0, 4);

    // Reset while a request is outstanding
    ack_enable = 1'b0;
    clear_src();
    for (int i = 0; i < 4; i++) add_byte(i, 8'($urandom_range(0, 255)));
    start_load(8'd1);
    send_bytes(1'b1, 1'b0);
    n = 0;
    while (!bus.ram_req && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("req_before_reset", {63'd0, bus.ram_req}, 64'd1);
    reset_n = 1'b0;
    bus.ioctl_download = 1'b0;
    #1;
    check("arst_req", {63'd0, bus.ram_req}, 64'd0);
    check("arst_addr", 64'(bus.ram_addr), 64'd0);
    check("arst_be", 64'(bus.ram_be), 64'd0);
    check("arst_ce", {63'd0, bus.ioctl_ce}, 64'd1);
    check("arst_busy", {63'd0, load_busy}, 64'd0);
    check("arst_size", 64'(load_size), 64'd0);
    check("arst_err", {63'd0, load_err}, 64'd0);
    check("arst_rom", {63'd0, rom_loaded}, 64'd0);
    repeat (2) @(negedge clk_sys);
    reset_n    = 1'b1;
    rom_exp    = 1'b0;
    err_exp    = 1'b0;
    ack_enable = 1'b1;
    @(negedge clk_sys);

    // Randomized loads after reset
    for (int r = 0; r < 6; r++) begin
      idx = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      ack_delay = $urandom_range(0, 3);
      clear_src();
      a = $urandom_range(0, 40);
      for (int i = 0, len = $urandom_range(1, 12); i < len; i++) begin
        add_byte(a, 8'($urandom_range(0, 255)));
        a = a + (($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 1);
      end
      start_load(idx);
      send_bytes(1'b1, 1'b1);
      finish_load(idx, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
